// File: rtl/sixbit_pow_seq.sv
// sixbit_pow_seq: multi-cycle 6-bit unsigned power unit (out = ain^bin).
// A single 6x6 multiplier is reused once per cycle; the exponent is clamped
// to MAX_EXP iterations. Overflow is sticky across the multiply chain.

module sixbitmul (
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic [5:0] prod,
  output logic       ovf
);

  logic [11:0] full;

  assign full = {6'b0, x} * {6'b0, y};
  assign prod = full[5:0];
  assign ovf  = |full[11:6];

endmodule

module sixbit_pow_seq #(
  parameter int MAX_EXP = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [5:0] ain,
  input  logic [5:0] bin,
  output logic       busy,
  output logic       done,
  output logic [5:0] out,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] a_q, a_d;
  logic [3:0] cnt_q, cnt_d;
  logic       zflag_q, zflag_d;
  logic [5:0] acc_q, acc_d;
  logic       ovacc_q, ovacc_d;
  logic [5:0] out_q, out_d;
  logic       overflow_q, overflow_d;

  logic [3:0] n_clamp;
  logic [5:0] mul_prod;
  logic       mul_ovf;

  // The one shared multiplier: running accumulator times captured base.
  sixbitmul u_mul (
    .x    (acc_q),
    .y    (a_q),
    .prod (mul_prod),
    .ovf  (mul_ovf)
  );

  // Iteration count is the exponent limited to MAX_EXP.
  always_comb begin
    n_clamp = bin[3:0];
    if (bin > 6'(MAX_EXP)) begin
      n_clamp = 4'(MAX_EXP);
    end
  end

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    cnt_d      = cnt_q;
    zflag_d    = zflag_q;
    acc_d      = acc_q;
    ovacc_d    = ovacc_q;
    out_d      = out_q;
    overflow_d = overflow_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = ain;
          cnt_d   = n_clamp;
          zflag_d = bin[5];
          acc_d   = 6'd1;
          ovacc_d = 1'b0;
          if (n_clamp != 4'd0) begin
            state_d = RUN;
          end else begin
            state_d    = DONE;
            out_d      = bin[5] ? 6'd0 : 6'd1;
            overflow_d = 1'b0;
          end
        end
      end
      RUN: begin
        acc_d   = mul_prod;
        ovacc_d = ovacc_q | mul_ovf;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = DONE;
          out_d      = zflag_q ? 6'd0 : mul_prod;
          overflow_d = ovacc_q | mul_ovf;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_q        <= 6'd0;
      cnt_q      <= 4'd0;
      zflag_q    <= 1'b0;
      acc_q      <= 6'd1;
      ovacc_q    <= 1'b0;
      out_q      <= 6'd0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      cnt_q      <= cnt_d;
      zflag_q    <= zflag_d;
      acc_q      <= acc_d;
      ovacc_q    <= ovacc_d;
      out_q      <= out_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign out      = out_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_sixbit_pow_seq.sv
// Testbench for sixbit_pow_seq: directed cases plus randomized operations
// compared against an arithmetic power model.

module tb_sixbit_pow_seq;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [5:0] ain;
  logic [5:0] bin;
  logic       busy;
  logic       done;
  logic [5:0] out;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  sixbit_pow_seq #(.MAX_EXP(10)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ain      (ain),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  // Reference: true power computed in 64 bits; overflow whenever it exceeds 63.
  task automatic refPow(input logic [5:0] a, input logic [5:0] b,
                        output logic [5:0] expOut, output logic expOvf, output int n);
    longint unsigned p;
    n = (b > 6'd10) ? 10 : int'(b);
    p = 1;
    for (int i = 0; i < n; i++) p = p * longint'(a);
    expOvf = (p > 63);
    expOut = b[5] ? 6'd0 : 6'(p % 64);
  endtask

  // Issue one operation from a negedge in IDLE and check timing and result.
  task automatic applyStimulus(input logic [5:0] a, input logic [5:0] b, input bit noisy);
    logic [5:0] expOut;
    logic       expOvf;
    int         n;
    int         cyc;
    bit         seen;
    logic [5:0] heldOut;
    refPow(a, b, expOut, expOvf, n);
    ain   = a;
    bin   = b;
    start = 1'b1;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
    start = 1'b0;
    ain   = 6'($urandom);
    bin   = 6'($urandom);
    cyc   = 1;
    seen  = 0;
    while (!seen && cyc <= 20) begin
      if (done === 1'b1) begin
        seen = 1;
      end else begin
        if (noisy) begin
          start = 1'($urandom);
          ain   = 6'($urandom);
          bin   = 6'($urandom);
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    checkOutput("done_seen", seen, 1);
    checkOutput("latency", cyc, n + 1);
    checkOutput("out", out, expOut);
    checkOutput("overflow", overflow, expOvf);
    heldOut = expOut;
    @(negedge clk);
    checkOutput("busy_idle", busy, 0);
    checkOutput("done_one_cycle", done, 0);
    checkOutput("out_held", out, heldOut);
  endtask

  initial begin
    int doneCount;
    rst_n = 1'b0;
    start = 1'b0;
    ain   = 6'd0;
    bin   = 6'd0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_out", out, 0);
    checkOutput("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] directed cases");
    applyStimulus(6'd2, 6'd3, 0);
    applyStimulus(6'd3, 6'd4, 0);
    applyStimulus(6'd5, 6'd0, 0);
    applyStimulus(6'd0, 6'd0, 0);
    applyStimulus(6'd2, 6'd12, 0);
    applyStimulus(6'd2, 6'd40, 0);
    applyStimulus(6'd1, 6'd63, 0);
    applyStimulus(6'd0, 6'd5, 0);
    applyStimulus(6'd63, 6'd1, 0);
    applyStimulus(6'd2, 6'd3, 1);
    applyStimulus(6'd7, 6'd1, 1);

    $display("[TB] reset during RUN");
    ain   = 6'd3;
    bin   = 6'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", busy, 0);
    checkOutput("midrun_reset_done", done, 0);
    checkOutput("midrun_reset_out", out, 0);
    checkOutput("midrun_reset_overflow", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) doneCount++;
    end
    checkOutput("no_done_after_reset", doneCount, 0);
    applyStimulus(6'd2, 6'd1, 0);

    $display("[TB] random operations");
    for (int i = 0; i < 60; i++) begin
      applyStimulus(6'($urandom), 6'($urandom_range(0, 63)), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
